// File: rtl/wb_regfile.sv
// Write-back select, 32-entry integer register file with same-cycle write-to-read bypass,
// and a retired-write counter.
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [DATA_W-1:0]       alu_data_W,
    input  logic [DATA_W-1:0]       read_data_W,
    input  logic [DATA_W-1:0]       pc_four_W,
    input  logic [$clog2(NREG)-1:0] rd_addr_W,
    input  logic [1:0]              wb_sel_W,
    input  logic                    rd_wren_W,
    input  logic [$clog2(NREG)-1:0] rs1_addr_D,
    input  logic [$clog2(NREG)-1:0] rs2_addr_D,
    output logic [DATA_W-1:0]       rs1_data_D,
    output logic [DATA_W-1:0]       rs2_data_D,
    output logic [DATA_W-1:0]       wb_data_W,
    output logic [31:0]             wb_count
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [31:0]       wb_count_q, wb_count_d;
    logic              commit;

    always_comb begin
        wb_data_W = alu_data_W;
        case (wb_sel_W)
            2'b01:   wb_data_W = read_data_W;
            2'b10:   wb_data_W = pc_four_W;
            default: wb_data_W = alu_data_W;
        endcase
    end

    assign commit = rd_wren_W && (rd_addr_W != '0) && !i_rst;

    // Bypass only on a real commit, so x0 and reset cycles never leak wb_data_W.
    always_comb begin
        rs1_data_D = '0;
        if (!i_rst && rs1_addr_D != '0) begin
            if (commit && rd_addr_W == rs1_addr_D) rs1_data_D = wb_data_W;
            else                                   rs1_data_D = regs_q[rs1_addr_D];
        end
    end

    always_comb begin
        rs2_data_D = '0;
        if (!i_rst && rs2_addr_D != '0) begin
            if (commit && rd_addr_W == rs2_addr_D) rs2_data_D = wb_data_W;
            else                                   rs2_data_D = regs_q[rs2_addr_D];
        end
    end

    always_comb begin
        wb_count_d = wb_count_q;
        if (commit) wb_count_d = wb_count_q + 32'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
            wb_count_q <= '0;
        end else begin
            if (commit) regs_q[rd_addr_W] <= wb_data_W;
            wb_count_q <= wb_count_d;
        end
    end

    assign wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: expectations are queued when stimulus is driven and
// compared against the DUT half a cycle later, before the committing edge.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] alu, mem, pc4;
    logic [4:0]  rd, rs1, rs2;
    logic [1:0]  sel;
    logic        wren;
    logic [31:0] rs1_data, rs2_data, wb_data, wb_cnt;

    wb_regfile #(.DATA_W(32), .NREG(32)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .alu_data_W (alu),
        .read_data_W(mem),
        .pc_four_W  (pc4),
        .rd_addr_W  (rd),
        .wb_sel_W   (sel),
        .rd_wren_W  (wren),
        .rs1_addr_D (rs1),
        .rs2_addr_D (rs2),
        .rs1_data_D (rs1_data),
        .rs2_data_D (rs2_data),
        .wb_data_W  (wb_data),
        .wb_count   (wb_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {SigRs1, SigRs2, SigWb, SigCnt} sig_e;
    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mregs [32];
    logic [31:0] mcount;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input sig_e sig, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] model_wb();
        case (sel)
            2'b01:   return mem;
            2'b10:   return pc4;
            default: return alu;
        endcase
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        if (rst || a == 5'd0) return 32'd0;
        if (wren && rd != 5'd0 && rd == a) return model_wb();
        return mregs[a];
    endfunction

    // Drain the scoreboard before the edge, then clock and advance the model.
    task automatic step();
        sb_t e;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sig)
                SigRs1:  check(e.tag, rs1_data, e.exp);
                SigRs2:  check(e.tag, rs2_data, e.exp);
                SigWb:   check(e.tag, wb_data, e.exp);
                default: check(e.tag, wb_cnt, e.exp);
            endcase
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
            mcount = 32'd0;
        end else if (wren && rd != 5'd0) begin
            mregs[rd] = model_wb();
            mcount    = mcount + 32'd1;
        end
        #1;
    endtask

    initial begin
        logic [31:0] mux_exp [4];
        mux_exp[0] = 32'h1111_1111;
        mux_exp[1] = 32'h2222_2222;
        mux_exp[2] = 32'h0000_0104;
        mux_exp[3] = 32'h1111_1111;
        for (int i = 0; i < 32; i++) mregs[i] = 32'hxxxx_xxxx;
        mcount = 32'hxxxx_xxxx;

        rst = 1'b1; alu = '0; mem = '0; pc4 = '0; rd = '0; sel = '0; wren = 1'b0;
        rs1 = 5'd3; rs2 = 5'd7;
        push("rst_rs1", SigRs1, 32'd0);
        push("rst_rs2", SigRs2, 32'd0);
        step();
        step();
        rst = 1'b0;

        // Reset then read every index.
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            push($sformatf("rst_rd1_x%0d", i), SigRs1, 32'd0);
            push($sformatf("rst_rd2_x%0d", 31 - i), SigRs2, 32'd0);
            if (i == 0) push("rst_cnt", SigCnt, 32'd0);
            step();
        end

        // Write-back mux plus commit.
        alu = 32'h1111_1111; mem = 32'h2222_2222; pc4 = 32'h0000_0104;
        for (int k = 0; k < 4; k++) begin
            rd = 5'(5 + k); sel = 2'(k); wren = 1'b1;
            push($sformatf("mux_sel%0d", k), SigWb, mux_exp[k]);
            step();
        end
        wren = 1'b0; rs1 = 5'd5; rs2 = 5'd6;
        push("mux_x5", SigRs1, 32'h1111_1111);
        push("mux_x6", SigRs2, 32'h2222_2222);
        step();
        rs1 = 5'd7; rs2 = 5'd8;
        push("mux_x7", SigRs1, 32'h0000_0104);
        push("mux_x8", SigRs2, 32'h1111_1111);
        push("mux_cnt", SigCnt, 32'd4);
        step();

        // Bypass on both ports, then back-to-back write to the same register.
        rd = 5'd10; sel = 2'b00; alu = 32'hDEAD_BEEF; wren = 1'b1; rs1 = 5'd10; rs2 = 5'd10;
        push("byp1_rs1", SigRs1, 32'hDEAD_BEEF);
        push("byp1_rs2", SigRs2, 32'hDEAD_BEEF);
        step();
        alu = 32'h0000_0001;
        push("byp2_rs1", SigRs1, 32'h0000_0001);
        push("byp2_rs2", SigRs2, 32'h0000_0001);
        push("byp2_cnt", SigCnt, 32'd5);
        step();
        wren = 1'b0; alu = 32'h5555_5555;
        push("byp_after", SigRs1, 32'h0000_0001);
        push("byp_cnt", SigCnt, 32'd6);
        step();

        // x0 protection.
        rd = 5'd0; alu = 32'hFFFF_FFFF; sel = 2'b00; wren = 1'b1; rs1 = 5'd0;
        push("x0_rs1", SigRs1, 32'd0);
        push("x0_wb", SigWb, 32'hFFFF_FFFF);
        push("x0_cnt", SigCnt, 32'd6);
        step();
        wren = 1'b0;
        push("x0_rs1_next", SigRs1, 32'd0);
        push("x0_cnt_next", SigCnt, 32'd6);
        step();

        // Disabled write.
        rd = 5'd3; alu = 32'd5; wren = 1'b0; rs1 = 5'd3;
        push("dis_rs1", SigRs1, 32'd0);
        step();
        push("dis_x3", SigRs1, 32'd0);
        push("dis_cnt", SigCnt, 32'd6);
        step();

        // Write colliding with reset is dropped.
        rst = 1'b1; rd = 5'd4; alu = 32'd9; wren = 1'b1; rs1 = 5'd4; rs2 = 5'd10;
        push("col_rs1", SigRs1, 32'd0);
        push("col_rs2", SigRs2, 32'd0);
        step();
        rst = 1'b0; wren = 1'b0;
        push("col_x4", SigRs1, 32'd0);
        push("col_x10", SigRs2, 32'd0);
        push("col_cnt", SigCnt, 32'd0);
        step();

        // Randomised traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            alu  = $urandom; mem = $urandom; pc4 = $urandom;
            sel  = 2'($urandom_range(0, 3));
            rd   = 5'($urandom_range(0, 7));
            wren = 1'($urandom_range(0, 1));
            rs1  = 5'($urandom_range(0, 7));
            rs2  = (n % 5 == 0) ? rd : 5'($urandom_range(0, 7));
            push($sformatf("rnd%0d_rs1", n), SigRs1, model_rd(rs1));
            push($sformatf("rnd%0d_rs2", n), SigRs2, model_rd(rs2));
            push($sformatf("rnd%0d_wb", n), SigWb, model_wb());
            push($sformatf("rnd%0d_cnt", n), SigCnt, mcount);
            step();
        end

        // Counter wrap through a preload of the count register.
        wren = 1'b0;
        force dut.wb_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count_q;
        mcount = 32'hFFFF_FFFF;
        rd = 5'd1; alu = 32'h1234_5678; sel = 2'b00; wren = 1'b1;
        push("wrap_pre", SigCnt, 32'hFFFF_FFFF);
        step();
        wren = 1'b0;
        push("wrap_zero", SigCnt, 32'd0);
        step();
        push("wrap_idle", SigCnt, 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
